// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store controller.
//   - funct3 encodings for the supported access sizes
//   - lsu_state_t controller state encoding
//   - merge_word  : replace a byte/half lane of a memory word with store data
//   - extend_load : extract a byte/half lane and sign/zero extend it
//   - f3_legal    : which funct3 codes are meaningful for loads vs stores
//   - sat_inc16   : saturating 16-bit increment for the optional statistics
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  // Unsigned variants only make sense for loads; a store carrying BU/HU is
  // treated as an illegal encoding.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Little-endian lane replacement. Byte lane = addr[1:0], half lane = addr[1].
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  lane);
    logic [31:0] w;
    w = old_word;
    case (f3)
      F3_B:    w[{lane, 3'b000} +: 8]      = wdata[7:0];
      F3_H:    w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: w = wdata;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lsu_align_chk.sv
// lsu_align_chk: combinational request error detection.
//   Flags an incoming request as erroneous when the funct3 code is illegal
//   (for its direction), when a half access is on an odd byte, when a word
//   access is not 4-byte aligned, or when the word index falls outside the
//   downstream memory.
// Ports:
//   funct3 [2:0]  access size / signedness code
//   we            1 = store, 0 = load
//   addr [AW-1:0] byte address
//   err           1 = request must be rejected without touching memory
module lsu_align_chk
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 32
) (
  input  logic [2:0]    funct3,
  input  logic          we,
  input  logic [AW-1:0] addr,
  output logic          err
);

  localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH_WORDS);

  logic          legal;
  logic          misalign;
  logic          range_err;
  logic [AW-1:0] word_idx;

  always_comb begin
    legal    = f3_legal(funct3, we);
    misalign = 1'b0;
    case (funct3)
      F3_H, F3_HU: misalign = addr[0];
      F3_W:        misalign = |addr[1:0];
      default:     misalign = 1'b0;
    endcase
  end

  assign word_idx  = addr >> 2;
  assign range_err = (word_idx >= DEPTH_L);
  assign err       = !legal || misalign || range_err;

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller in front of a word-addressed single-cycle
// RAM (synchronous write, combinational read). Converts byte-addressed
// LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses, doing
// read-modify-write for sub-word stores and sign/zero extension for loads.
//
// Optional build macro: LSU_STATS_EN adds saturating load/store/error
// counters (stat_loads, stat_stores, stat_errs).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid / req_ready    request handshake, ready only in IDLE
//   req_we, req_funct3       direction and access size
//   req_addr, req_wdata      byte address, store data (low lane used)
//   resp_valid               one-cycle response pulse
//   resp_rdata, resp_err     extended load data (0 on store/error), error flag
//   mem_A, mem_WD, mem_we    word address, write word, write enable to memory
//   mem_RD                   combinational read word from memory
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request, mem_A = 0
// RD     | mem_A driven, memory word captured (load or sub-word store)
// WR     | mem_we high for exactly this cycle
// RESP   | resp_valid high with registered rdata/err
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [31:0]   mem_A,
  output logic [31:0]   mem_WD,
  output logic          mem_we,
`ifdef LSU_STATS_EN
  output logic [15:0]   stat_loads,
  output logic [15:0]   stat_stores,
  output logic [15:0]   stat_errs,
`endif
  input  logic [31:0]   mem_RD
);

  lsu_state_t  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic        chk_err;
  logic        accept;
  logic [31:0] req_word;

  lsu_align_chk #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_align_chk (
    .funct3 (req_funct3),
    .we     (req_we),
    .addr   (req_addr),
    .err    (chk_err)
  );

  assign accept   = req_valid && req_ready;
  assign req_word = 32'(req_addr >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_A      <= 32'h0;
      mem_WD     <= 32'h0;
      mem_we     <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      lane_q     <= 2'b00;
      wdata_q    <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (chk_err) begin
              // Rejected requests never reach memory; mem_A stays 0.
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_we && (req_funct3 == F3_W)) begin
              // Full-word store needs no read, write goes out next cycle.
              state  <= S_WR;
              mem_A  <= req_word;
              mem_WD <= req_wdata;
              mem_we <= 1'b1;
            end else begin
              state <= S_RD;
              mem_A <= req_word;
            end
          end
        end

        S_RD: begin
          if (we_q) begin
            // mem_WD doubles as the captured word buffer with the lane merged.
            state  <= S_WR;
            mem_WD <= merge_word(mem_RD, wdata_q, f3_q, lane_q);
            mem_we <= 1'b1;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= extend_load(mem_RD, f3_q, lane_q);
          end
        end

        S_WR: begin
          state      <= S_RESP;
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end

        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          mem_A      <= 32'h0;
          mem_WD     <= 32'h0;
          req_ready  <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          mem_we    <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef LSU_STATS_EN
  // An errored store counts only as an error, never as a store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_loads  <= 16'h0;
      stat_stores <= 16'h0;
      stat_errs   <= 16'h0;
    end else if (state == S_RESP) begin
      if (resp_err)
        stat_errs <= sat_inc16(stat_errs);
      else if (we_q)
        stat_stores <= sat_inc16(stat_stores);
      else
        stat_loads <= sat_inc16(stat_loads);
    end
  end
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed plus randomized bench for lsu_ctrl with a bench-side
// memory and an arithmetic reference model of the expected memory contents.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_we;
  logic [31:0] mem_RD;
`ifdef LSU_STATS_EN
  logic [15:0] stat_loads;
  logic [15:0] stat_stores;
  logic [15:0] stat_errs;
`endif

  lsu_ctrl #(.DEPTH_WORDS(256), .AW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_we     (mem_we),
`ifdef LSU_STATS_EN
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs),
`endif
    .mem_RD     (mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-owned RAM: synchronous write, combinational read.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_val;

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (mem_we && (mem_A < 32'd256)) mem[mem_A[7:0]] <= mem_WD;
  end
  assign mem_RD = (mem_A < 32'd256) ? mem[mem_A[7:0]] : 32'h0;

  int          we_pulses;
  int          resp_pulses;
  logic [31:0] last_wd;
  initial begin
    we_pulses = 0;
    resp_pulses = 0;
    last_wd = 32'h0;
  end
  always @(negedge clk) begin
    if (mem_we) begin
      we_pulses <= we_pulses + 1;
      last_wd   <= mem_WD;
    end
    if (resp_valid) resp_pulses <= resp_pulses + 1;
  end

  int n_chk;
  int n_pass;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: expected outcome from the access rules, updating ref_mem.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err,
                       output int lat, output int pulses, output logic [31:0] wword);
    int          sz;
    bit          sgn;
    bit          ok;
    int          idx;
    int          sh;
    logic [31:0] mask;
    logic [31:0] v;
    ok = 1; sgn = 0; sz = 4;
    case (f3)
      3'd0: begin sz = 1; sgn = 1; end
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: sz = 4;
      3'd4: begin sz = 1; ok = !we; end
      3'd5: begin sz = 2; ok = !we; end
      default: ok = 0;
    endcase
    err = !ok || ((addr % 32'(sz)) != 0) || ((addr / 4) >= 32'd256);
    rd = 32'h0; wword = 32'h0; pulses = 0; lat = 1;
    if (err) return;
    idx  = int'(addr / 4);
    sh   = int'(addr % 4) * 8;
    mask = (sz == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * sz)) - 32'd1) << sh);
    if (we) begin
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << sh) & mask);
      wword  = ref_mem[idx];
      pulses = 1;
      lat    = (sz == 4) ? 2 : 3;
    end else begin
      v = (ref_mem[idx] & mask) >> sh;
      if (sgn && v[8 * sz - 1]) v = v | ~(mask >> sh);
      rd  = v;
      lat = 2;
    end
  endtask

  // One complete transaction; entered and left at #1 after a rising edge.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] e_rd;
    logic [31:0] e_wd;
    logic        e_err;
    int          e_lat;
    int          e_pulses;
    int          lat;
    int          n;
    int          p0;
    model(we, f3, addr, wd, e_rd, e_err, e_lat, e_pulses, e_wd);
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    chk({tag, "/ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    p0 = we_pulses;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 8) begin
      chk({tag, "/ready_busy"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1; lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "/rdata"}, resp_rdata, e_rd);
    chk({tag, "/err"}, 32'(resp_err), 32'(e_err));
    chk({tag, "/ready_resp"}, 32'(req_ready), 32'd0);
    if (!e_err) chk({tag, "/mem_A"}, mem_A, addr >> 2);
    @(posedge clk); #1;
    chk({tag, "/valid_drop"}, 32'(resp_valid), 32'd0);
    chk({tag, "/ready_back"}, 32'(req_ready), 32'd1);
    chk({tag, "/mem_A_idle"}, mem_A, 32'h0);
    chk({tag, "/we_pulses"}, 32'(we_pulses - p0), 32'(e_pulses));
    if (e_pulses > 0) chk({tag, "/mem_WD"}, last_wd, e_wd);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "/resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "/resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, "/resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "/mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "/mem_A"}, mem_A, 32'h0);
    chk({tag, "/mem_WD"}, mem_WD, 32'h0);
  endtask

  initial begin
    logic [31:0] e_rd;
    logic [31:0] e_wd;
    logic        e_err;
    int          e_lat;
    int          e_pulses;
    int          p0;
    int          r0;
    int          n;
    int          nbad;
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr;
    logic [2:0]  st_codes [4];
    logic [2:0]  ld_codes [8];

    n_chk = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    ld_en = 1'b0; ld_idx = 8'h0; ld_val = 32'h0;
    st_codes = '{3'd0, 3'd1, 3'd2, 3'd4};
    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    // Load memory contents while the controller sits in reset.
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      ld_en  = 1'b1;
      ld_idx = 8'(i);
      ld_val = (i == 3) ? 32'h8899AABB : (i == 5) ? 32'h11223344 : $urandom;
      ref_mem[i] = ld_val;
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    do_req("lb_0d",  1'b0, 3'd0, 32'h0D, 32'h0);
    chk("lb_0d_val", resp_rdata, 32'h0);
    do_req("lhu_0e", 1'b0, 3'd5, 32'h0E, 32'h0);
    do_req("lh_0e",  1'b0, 3'd1, 32'h0E, 32'h0);
    do_req("sb_15",  1'b1, 3'd0, 32'h15, 32'hDEADBEEF);
    chk("sb_15_word", ref_mem[5], 32'h1122EF44);
    do_req("lw_14",  1'b0, 3'd2, 32'h14, 32'h0);
    do_req("sh_16",  1'b1, 3'd1, 32'h16, 32'hCAFE1234);
    do_req("lbu_17", 1'b0, 3'd4, 32'h17, 32'h0);

    do_req("err_lw_22",  1'b0, 3'd2, 32'h22, 32'h0);
    do_req("err_sh_21",  1'b1, 3'd1, 32'h21, 32'h5555);
    do_req("err_f3_011", 1'b0, 3'd3, 32'h00, 32'h0);
    do_req("err_oob",    1'b0, 3'd2, 32'h400, 32'h0);
    do_req("edge_last",  1'b0, 3'd2, 32'h3FC, 32'h0);

    // Four SW requests with req_valid held high throughout.
    p0 = we_pulses;
    r0 = resp_pulses;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    for (int k = 0; k < 4; k++) begin
      req_addr  = 32'h40 + 32'(4 * k);
      req_wdata = $urandom;
      model(1'b1, 3'd2, req_addr, req_wdata, e_rd, e_err, e_lat, e_pulses, e_wd);
      chk("b2b/ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      if (k == 3) req_valid = 1'b0;
      n = 0;
      while (req_ready !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
      chk("b2b/busy_cycles", 32'(n), 32'd2);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b2b/we_pulses", 32'(we_pulses - p0), 32'd4);
    chk("b2b/resp_pulses", 32'(resp_pulses - r0), 32'd4);
    for (int k = 0; k < 4; k++) chk("b2b/word", mem[16 + k], ref_mem[16 + k]);

    // Reset during the RD cycle of a byte store.
    p0 = we_pulses;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
    req_addr = 32'h1E; req_wdata = 32'h000000A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid/in_rd_mem_A", mem_A, 32'h7);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid/we_pulses", 32'(we_pulses - p0), 32'd0);
    chk("rst_mid/word", mem[7], ref_mem[7]);

    // Randomized traffic mostly within words 0..15 to create read-after-write hits.
    for (int t = 0; t < 60; t++) begin
      rwe   = 1'($urandom_range(0, 1));
      raddr = ($urandom_range(0, 11) == 0) ? 32'($urandom_range(1024, 2047))
                                           : 32'($urandom_range(0, 63));
      if (rwe) rf3 = st_codes[$urandom_range(0, 3)];
      else rf3 = ld_codes[$urandom_range(0, 7)];
      do_req("rand", rwe, rf3, raddr, $urandom);
    end

    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
    chk("final_mem_words_bad", 32'(nbad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
